count_sequence_checker: RTL and testbench

Observes the 4-bit value stream produced by the board's up/down counter and checks it against the counting rules:
- step of 1 or 3;
- increasing or decreasing;
- modulo-2^NBITS wrap;
- hold for freeze or saturation;
- return to 0 on counter reset.

It learns direction and step from the first two samples. After that it reports lock, the next expected value, per-sample mismatch pulses and a saturating error count. Its outputs drive LEDs and the LCD register view in the top-level lab wrapper.

---
 rtl/count_sequence_checker.sv | 111 +++++++++++
 tb/tb_count_sequence_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_checker.sv
// Checks an up/down counter's value stream: learns direction and step from two
// samples, then flags samples that are neither the next count, a hold, nor a restart at 0.
module count_sequence_checker #(
    parameter int NBITS     = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [NBITS-1:0] in_value,
    output logic             locked,
    output logic             dir_down,
    output logic             step3,
    output logic [NBITS-1:0] expected,
    output logic             mismatch,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, LOCKED} state_t;

    state_t           state_reg, state_next;
    logic [NBITS-1:0] prev_reg, prev_next;
    logic [3:0]       consec_reg, consec_next;
    logic             dir_reg, dir_next;
    logic             step3_reg, step3_next;
    logic             mismatch_reg, mismatch_next;
    logic [7:0]       err_reg, err_next;

    logic [NBITS-1:0] step_val;
    logic [NBITS-1:0] pred;
    logic [NBITS-1:0] delta;
    logic             accept;

    // Prediction wraps naturally through the NBITS-wide arithmetic.
    assign step_val = step3_reg ? NBITS'(3) : NBITS'(1);
    assign pred     = dir_reg ? (prev_reg - step_val) : (prev_reg + step_val);
    assign delta    = in_value - prev_reg;
    assign accept   = (in_value == pred) || (in_value == prev_reg) || (in_value == '0);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_reg    <= EMPTY;
            prev_reg     <= '0;
            consec_reg   <= '0;
            dir_reg      <= 1'b0;
            step3_reg    <= 1'b0;
            mismatch_reg <= 1'b0;
            err_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            prev_reg     <= prev_next;
            consec_reg   <= consec_next;
            dir_reg      <= dir_next;
            step3_reg    <= step3_next;
            mismatch_reg <= mismatch_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        prev_next     = prev_reg;
        consec_next   = consec_reg;
        dir_next      = dir_reg;
        step3_next    = step3_reg;
        mismatch_next = 1'b0;
        err_next      = err_reg;
        if (in_valid) begin
            prev_next = in_value;
            case (state_reg)
                EMPTY: state_next = ONE;
                ONE: begin
                    if (delta == NBITS'(1) || delta == NBITS'(3) ||
                        delta == {NBITS{1'b1}} || delta == NBITS'((2 ** NBITS) - 3)) begin
                        state_next  = LOCKED;
                        consec_next = '0;
                        dir_next    = delta[NBITS-1];
                        step3_next  = (delta == NBITS'(3)) || (delta == NBITS'((2 ** NBITS) - 3));
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        consec_next = '0;
                    end else begin
                        mismatch_next = 1'b1;
                        if (err_reg != 8'hFF)
                            err_next = err_reg + 8'd1;
                        // Too many misses in a row: drop lock and relearn the mode.
                        if (consec_reg + 4'd1 == 4'(ERR_LIMIT)) begin
                            state_next  = ONE;
                            consec_next = '0;
                        end else begin
                            consec_next = consec_reg + 4'd1;
                        end
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        locked   = (state_reg == LOCKED);
        dir_down = dir_reg;
        step3    = step3_reg;
        expected = locked ? pred : '0;
        mismatch = mismatch_reg;
        err_cnt  = err_reg;
    end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Scoreboard bench: a behavioural model queues the expected outputs for each
// driven cycle, which are compared one cycle later against the checker.
module tb_count_sequence_checker;

    localparam int NBITS     = 4;
    localparam int ERR_LIMIT = 3;
    localparam int MOD       = 1 << NBITS;

    logic             clk_2 = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [NBITS-1:0] in_value = '0;
    logic             locked, dir_down, step3, mismatch;
    logic [NBITS-1:0] expected;
    logic [7:0]       err_cnt;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        bit locked;
        bit dir_down;
        bit step3;
        int expected;
        bit mismatch;
        int err_cnt;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    int m_state = 0;  // 0 empty, 1 one, 2 locked
    int m_prev = 0, m_consec = 0, m_err = 0;
    bit m_down = 0, m_s3 = 0, m_mis = 0;

    count_sequence_checker #(.NBITS(NBITS), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk_2(clk_2), .reset(reset), .in_valid(in_valid), .in_value(in_value),
        .locked(locked), .dir_down(dir_down), .step3(step3), .expected(expected),
        .mismatch(mismatch), .err_cnt(err_cnt)
    );

    always #5 clk_2 = ~clk_2;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int want);
        n_total++;
        if (obs != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    function automatic int m_pred();
        int s;
        if (m_state != 2) return 0;
        s = m_s3 ? 3 : 1;
        return m_down ? (m_prev - s + MOD) % MOD : (m_prev + s) % MOD;
    endfunction

    function automatic exp_t m_snapshot();
        exp_t e;
        e.locked   = (m_state == 2);
        e.dir_down = m_down;
        e.step3    = m_s3;
        e.expected = m_pred();
        e.mismatch = m_mis;
        e.err_cnt  = m_err;
        return e;
    endfunction

    task automatic m_reset();
        m_state = 0; m_prev = 0; m_consec = 0; m_err = 0;
        m_down = 0; m_s3 = 0; m_mis = 0;
    endtask

    task automatic m_sample(input int v);
        int d;
        int e;
        m_mis = 0;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            d = (v - m_prev + MOD) % MOD;
            if (d == 1 || d == 3 || d == MOD - 1 || d == MOD - 3) begin
                m_state  = 2;
                m_consec = 0;
                m_down   = (d > MOD / 2);
                m_s3     = (d == 3 || d == MOD - 3);
            end
        end else begin
            e = m_pred();
            if (v == e || v == m_prev || v == 0) begin
                m_consec = 0;
            end else begin
                m_mis = 1;
                if (m_err < 255) m_err++;
                m_consec++;
                if (m_consec == ERR_LIMIT) begin
                    m_state  = 1;
                    m_consec = 0;
                end
            end
        end
        m_prev = v;
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb_q.pop_front();
        $display("cycle %0t %s: in_valid=%0d in_value=%0d locked=%0d dir=%0d s3=%0d exp=%0d mis=%0d err=%0d",
                 $time, tag, in_valid, in_value, locked, dir_down, step3, expected, mismatch, err_cnt);
        chk({tag, "_locked"}, locked, e.locked);
        chk({tag, "_expected"}, expected, e.expected);
        chk({tag, "_mismatch"}, mismatch, e.mismatch);
        chk({tag, "_err_cnt"}, err_cnt, e.err_cnt);
        if (e.locked) begin
            chk({tag, "_dir_down"}, dir_down, e.dir_down);
            chk({tag, "_step3"}, step3, e.step3);
        end
    endtask

    task automatic drive(input bit valid, input int v, input string tag);
        @(negedge clk_2);
        in_valid = valid;
        in_value = NBITS'(v);
        if (valid) m_sample(v);
        else       m_mis = 0;
        sb_q.push_back(m_snapshot());
        @(posedge clk_2);
        #1;
        compare_head(tag);
    endtask

    task automatic do_reset(input int v);
        @(negedge clk_2);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_value = NBITS'(v);
        m_reset();
        sb_q.push_back(m_snapshot());
        @(posedge clk_2);
        #1;
        compare_head("reset");
        chk("reset_dir_down", dir_down, 0);
        chk("reset_step3", step3, 0);
        @(negedge clk_2);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic feed(input int vals[$], input string tag);
        foreach (vals[i]) drive(1'b1, vals[i], tag);
    endtask

    initial begin
        int r, v;
        // learn up/1, with an ignored idle cycle
        do_reset(0);
        feed('{2, 3}, "up1");
        drive(1'b0, 9, "up1_idle");
        feed('{4, 5}, "up1");
        chk("up1_plan_expected", expected, 6);
        chk("up1_plan_dir", dir_down, 0);
        chk("up1_plan_err", err_cnt, 0);

        // learn down/3 with wrap
        do_reset(0);
        feed('{1, 14, 11, 8, 5, 2, 15}, "dn3");
        chk("dn3_plan_expected", expected, 12);
        chk("dn3_plan_dir", dir_down, 1);
        chk("dn3_plan_step3", step3, 1);
        chk("dn3_plan_err", err_cnt, 0);

        // hold and restart
        do_reset(0);
        feed('{13, 14, 15, 15, 15, 0, 1}, "hold");
        chk("hold_plan_expected", expected, 2);
        chk("hold_plan_err", err_cnt, 0);

        // single error resync
        do_reset(0);
        feed('{5, 6, 9}, "resync");
        chk("resync_plan_mis", mismatch, 1);
        feed('{10}, "resync");
        chk("resync_plan_mis2", mismatch, 0);
        chk("resync_plan_err", err_cnt, 1);
        chk("resync_plan_locked", locked, 1);

        // lock loss after ERR_LIMIT consecutive misses, then relock
        do_reset(0);
        feed('{5, 6, 9, 2, 12}, "loss");
        chk("loss_plan_locked", locked, 0);
        chk("loss_plan_err", err_cnt, 3);
        feed('{13}, "loss");
        chk("loss_plan_relock", locked, 1);
        chk("loss_plan_step3", step3, 0);

        // reset mid-operation while locked down/1 with two errors
        do_reset(0);
        feed('{10, 9, 3, 2, 9, 8}, "mid");
        chk("mid_plan_err", err_cnt, 2);
        chk("mid_plan_locked", locked, 1);
        do_reset(7);
        chk("mid_plan_reset_err", err_cnt, 0);
        feed('{7, 4}, "mid");
        chk("mid_plan_dir", dir_down, 1);
        chk("mid_plan_step3", step3, 1);
        chk("mid_plan_expected", expected, 1);

        // random stream, long enough to saturate err_cnt
        do_reset(0);
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      v = m_pred();
            else if (r < 5) v = m_prev;
            else            v = int'($urandom_range(0, MOD - 1));
            drive($urandom_range(0, 4) != 0, v, "rand");
        end
        chk("rand_err_saturated", err_cnt, m_err);
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
